// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory port between instruction fetch and the load/store path.
// One transaction at a time is sequenced through a req/ack handshake with the
// memory. Data accesses win arbitration, but a saturating streak counter forces
// a fetch grant after MAX_D_STREAK consecutive data grants made while fetch was
// waiting, so fetch is never starved.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   i_req, i_addr     fetch request (read only)
//   i_ack, i_rdata    one-cycle completion pulse, registered fetched word
//   d_req, d_we,      data request: we=1 store, we=0 load
//   d_addr, d_wdata
//   d_ack, d_rdata    one-cycle completion pulse, registered loaded word
//   mem_req, mem_we,  memory request; address/data/we latched at grant time
//   mem_addr, mem_wdata
//   mem_ack, mem_rdata memory completion (one cycle), read data valid with ack
//   busy              high whenever the arbiter is not idle
//
// Timing: request seen in IDLE at cycle k -> mem_req at k+1; mem_ack at k+1
// -> x_ack at k+2 -> IDLE at k+3. Every output is a flop, so nothing on the
// memory side depends combinationally on mem_ack.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,

  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,

  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  // Streak counter spans 0..MAX_D_STREAK inclusive.
  localparam int            SW         = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY_I,
    S_BUSY_D,
    S_DONE_I,
    S_DONE_D
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] streak;
  logic [SW-1:0] streak_nxt;
  logic          grant_i;
  logic          grant_d;

  // ---------------------------------------------------------------------------
  // Next-state, arbitration and streak update
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    state_nxt  = state;
    streak_nxt = streak;
    grant_i    = 1'b0;
    grant_d    = 1'b0;

    case (state)
      S_IDLE: begin
        // Data wins unless fetch is waiting and the data streak is exhausted.
        if (d_req && !(i_req && (streak == STREAK_MAX))) begin
          grant_d   = 1'b1;
          state_nxt = S_BUSY_D;
          // Only data grants that kept fetch waiting count toward the streak.
          if (!i_req) begin
            streak_nxt = '0;
          end else if (streak != STREAK_MAX) begin
            streak_nxt = streak + SW'(1);
          end
        end else if (i_req) begin
          grant_i    = 1'b1;
          state_nxt  = S_BUSY_I;
          streak_nxt = '0;
        end
      end

      S_BUSY_I: if (mem_ack) state_nxt = S_DONE_I;
      S_BUSY_D: if (mem_ack) state_nxt = S_DONE_D;

      S_DONE_I,
      S_DONE_D: state_nxt = S_IDLE;

      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state  <= S_IDLE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  //
  // Status outputs are decoded from the next state so they line up with the
  // state register while still leaving the block straight from flops.
  // Address, write data and we are latched only on the grant edge; the
  // requester may change its inputs during BUSY without affecting the memory.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      mem_req <= (state_nxt == S_BUSY_I) || (state_nxt == S_BUSY_D);
      busy    <= (state_nxt != S_IDLE);
      i_ack   <= (state_nxt == S_DONE_I);
      d_ack   <= (state_nxt == S_DONE_D);

      if (grant_d) begin
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_we    <= d_we;
      end else if (grant_i) begin
        // Fetch is always a read; the stale write data is harmless.
        mem_addr  <= i_addr;
        mem_we    <= 1'b0;
      end

      // Read data is captured on the ack edge and held until the next read
      // for the same requester; stores leave d_rdata untouched.
      if ((state == S_BUSY_I) && mem_ack) begin
        i_rdata <= mem_rdata;
      end
      if ((state == S_BUSY_D) && mem_ack && !mem_we) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A transaction-level reference model
// (idle / memory-busy / acknowledge phases plus a grant history) predicts every
// output cycle by cycle, while the bench plays both requesters and the memory.
// Directed scenarios come first, then a long randomized run.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAXS)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_BUSY, M_DONE} phase_t;
  typedef struct packed {
    logic is_d;           // grant went to data
    logic fetch_waiting;  // fetch was requesting at that grant
  } grant_t;

  phase_t        phase = M_IDLE;
  logic          cur_i = 1'b0;
  logic          cur_we = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wdata = '0;
  logic [DW-1:0] exp_i_rdata = '0;
  logic [DW-1:0] exp_d_rdata = '0;
  int            wait_left = 0;
  grant_t        hist[$];

  // Stimulus knobs
  int            p_i = 0, p_d = 0, p_garble = 0, p_stray = 0;
  int            wait_fixed = -1;
  bit            persistent = 1'b0;
  bit            rdata_fixed_en = 1'b0;
  logic [DW-1:0] rdata_fixed = '0;

  // Observations
  int            n_i_ack = 0, n_d_ack = 0, n_busy = 0;
  bit            ack_seq[$];

  function automatic int pct();
    return int'($urandom_range(99));
  endfunction

  // Fetch has its turn once the most recent MAXS grants were all data grants
  // that each left fetch waiting.
  function automatic bit fetch_turn();
    int run = 0;
    for (int k = hist.size() - 1; k >= 0; k--) begin
      if (hist[k].is_d && hist[k].fetch_waiting) run++;
      else break;
    end
    return run >= MAXS;
  endfunction

  task automatic clear_stats();
    n_i_ack = 0;
    n_d_ack = 0;
    n_busy  = 0;
    ack_seq.delete();
  endtask

  task automatic check_outputs();
    check("mem_req", mem_req, phase == M_BUSY);
    check("busy", busy, phase != M_IDLE);
    check("i_ack", i_ack, (phase == M_DONE) && cur_i);
    check("d_ack", d_ack, (phase == M_DONE) && !cur_i);
    if (phase == M_BUSY) begin
      check("mem_addr", mem_addr, cur_addr);
      check("mem_we", mem_we, cur_we);
      if (cur_we) check("mem_wdata", mem_wdata, cur_wdata);
      n_busy++;
    end
    check("i_rdata", i_rdata, exp_i_rdata);
    check("d_rdata", d_rdata, exp_d_rdata);
    if (i_ack) begin n_i_ack++; ack_seq.push_back(1'b0); end
    if (d_ack) begin n_d_ack++; ack_seq.push_back(1'b1); end
  endtask

  // Drive requester and memory inputs for the coming edge, then move the
  // model to the phase that edge should produce.
  task automatic advance();
    logic gd;
    if (phase == M_DONE) begin
      if (cur_i) begin
        if (persistent) i_addr = $urandom; else i_req = 1'b0;
      end else begin
        if (persistent) begin
          d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(1));
        end else d_req = 1'b0;
      end
    end
    if (!i_req) begin
      i_addr = $urandom;
      if (!(phase == M_DONE && cur_i) && pct() < p_i) i_req = 1'b1;
    end
    if (!d_req) begin
      d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(1));
      if (!(phase == M_DONE && !cur_i) && pct() < p_d) d_req = 1'b1;
    end
    if (phase == M_BUSY && pct() < p_garble) begin
      if (cur_i) i_addr = $urandom;
      else begin
        d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(1));
      end
    end

    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (phase == M_BUSY) begin
      if (wait_left == 0) begin
        mem_ack = 1'b1;
        if (rdata_fixed_en) mem_rdata = rdata_fixed;
      end else begin
        wait_left--;
      end
    end else if (pct() < p_stray) begin
      mem_ack = 1'b1;
    end

    case (phase)
      M_IDLE: if (i_req || d_req) begin
        gd = d_req && !(i_req && fetch_turn());
        hist.push_back(grant_t'({gd, i_req}));
        if (hist.size() > 32) void'(hist.pop_front());
        cur_i     = !gd;
        cur_addr  = gd ? d_addr : i_addr;
        cur_we    = gd && d_we;
        cur_wdata = d_wdata;
        wait_left = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(3));
        phase     = M_BUSY;
      end
      M_BUSY: if (mem_ack) begin
        if (cur_i) exp_i_rdata = mem_rdata;
        else if (!cur_we) exp_d_rdata = mem_rdata;
        phase = M_DONE;
      end
      default: phase = M_IDLE;
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      check_outputs();
      advance();
    end
  endtask

  task automatic do_reset(input bit check_first);
    @(negedge clk);
    if (check_first) check_outputs();
    rst     = 1'b1;
    i_req   = 1'b0;
    d_req   = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_i_ack", i_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_busy", busy, 0);
    rst         = 1'b0;
    phase       = M_IDLE;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    hist.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    do_reset(1'b0);

    // Single fetch, memory answers in the first request cycle.
    clear_stats();
    wait_fixed = 0; rdata_fixed_en = 1'b1; rdata_fixed = 32'h2402_0005;
    i_req = 1'b1; i_addr = 32'h40;
    advance();
    run(6);
    check("fetch_i_acks", n_i_ack, 1);
    check("fetch_d_acks", n_d_ack, 0);
    check("fetch_i_rdata", i_rdata, 32'h2402_0005);

    // Load while the requester scribbles over its inputs during BUSY.
    clear_stats();
    wait_fixed = 2; rdata_fixed = 32'h1234_5678; p_garble = 100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    advance();
    run(8);
    p_garble = 0;
    check("load_d_acks", n_d_ack, 1);
    check("load_d_rdata", d_rdata, 32'h1234_5678);

    // Store with three memory wait cycles; d_rdata must keep the load value.
    clear_stats();
    wait_fixed = 3; rdata_fixed_en = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    advance();
    run(8);
    check("store_busy_cycles", n_busy, 4);
    check("store_d_acks", n_d_ack, 1);
    check("store_d_rdata", d_rdata, 32'h1234_5678);

    // Both requesters held high: D,D,D,D,I repeating.
    do_reset(1'b1);
    clear_stats();
    wait_fixed = -1; persistent = 1'b1;
    i_req = 1'b1; i_addr = $urandom;
    d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(1));
    advance();
    run(80);
    check("streak_ack_count", ack_seq.size() >= 10, 1);
    for (int j = 0; j < 10 && j < ack_seq.size(); j++) begin
      check($sformatf("streak_seq%0d", j), ack_seq[j], (j % 5) != 4);
    end
    persistent = 1'b0;

    // Reset while a fetch is stuck waiting for memory, then a normal fetch.
    do_reset(1'b1);
    wait_fixed = 1000;
    i_req = 1'b1; i_addr = 32'h80;
    advance();
    run(3);
    do_reset(1'b1);
    clear_stats();
    wait_fixed = -1;
    i_req = 1'b1; i_addr = 32'h84;
    advance();
    run(8);
    check("post_rst_i_acks", n_i_ack, 1);
    check("post_rst_d_acks", n_d_ack, 0);

    // Stray memory acks while idle.
    clear_stats();
    p_stray = 100;
    run(6);
    p_stray = 0;
    check("stray_acks", n_i_ack + n_d_ack, 0);
    check("stray_busy_cycles", n_busy, 0);

    // Randomized traffic.
    do_reset(1'b1);
    clear_stats();
    p_i = 35; p_d = 35; p_garble = 15; p_stray = 10; wait_fixed = -1;
    run(3000);
    check("rand_some_i_acks", n_i_ack > 0, 1);
    check("rand_some_d_acks", n_d_ack > 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
